// File: rtl/fp8_cim_pkg.sv
// Shared types and sizing for the fp8 CIM vector sequencer.
// Elements are fp8 1-5-2 (sign, exponent, mantissa); the vector is N_ELEM of them.
package fp8_cim_pkg;
    localparam int FP8_W      = 8;
    localparam int EXP_W      = 5;
    localparam int MANT_W     = 2;
    localparam int N_ELEM     = 36;
    localparam int EPB        = 4;
    localparam int BEAT_W     = FP8_W * EPB;
    localparam int BEATS      = N_ELEM / EPB;
    localparam int BEAT_CNT_W = $clog2(BEATS);
    localparam int TMO_CYC    = 255;
    localparam int TMO_W      = 8;

    typedef logic [FP8_W-1:0] fp8_t;

    typedef enum logic [1:0] {FILL, ISSUE, WAIT} seq_state_t;
endpackage

// File: rtl/fp8_vec_buffer.sv
// N_ELEM x fp8 vector register written one beat (EPB elements) at a time.
// Only a synchronous reset clears it; contents persist across operations.
module fp8_vec_buffer
    import fp8_cim_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [BEAT_CNT_W-1:0] wr_beat,
    input  logic [BEAT_W-1:0]     wr_data,
    output fp8_t [N_ELEM-1:0]     vec
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BEATS; b++) begin
                if (wr_beat == BEAT_CNT_W'(b)) begin
                    for (int k = 0; k < EPB; k++) begin
                        vec[b*EPB + k] <= wr_data[FP8_W*k +: FP8_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fp8_cim_sequencer.sv
// Collects fp8 beats into the vector register, pulses cim_start once the vector is
// full, then waits for cim_done with a timeout before rearming for the next vector.
module fp8_cim_sequencer
    import fp8_cim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              abort,
    output fp8_t [N_ELEM-1:0] vec,
    output logic              vec_valid,
    output logic              cim_start,
    input  logic              cim_done,
    output logic              busy,
    output logic              err_tmo
);

    seq_state_t             state, state_nxt;
    logic [BEAT_CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic [TMO_W-1:0]       tmo_cnt, tmo_cnt_nxt;
    logic                   cim_start_nxt, vec_valid_nxt, busy_nxt, err_tmo_nxt;
    logic                   accept, last_beat, tmo_hit;

    // A beat transfers on in_valid & in_ready; abort blocks acceptance in the same cycle.
    assign in_ready  = (state == FILL) & ~abort;
    assign accept    = in_valid & in_ready;
    assign last_beat = (beat_cnt == BEAT_CNT_W'(BEATS - 1));
    assign tmo_hit   = (tmo_cnt == TMO_W'(TMO_CYC));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            beat_cnt  <= '0;
            tmo_cnt   <= '0;
            cim_start <= 1'b0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            err_tmo   <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            cim_start <= cim_start_nxt;
            vec_valid <= vec_valid_nxt;
            busy      <= busy_nxt;
            err_tmo   <= err_tmo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept && last_beat) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cim_done || tmo_hit) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
        if (abort) state_nxt = FILL;
    end

    // Done beats a coincident timeout, so the error flag is only set without done.
    always_comb begin
        beat_cnt_nxt = beat_cnt;
        if (accept) beat_cnt_nxt = last_beat ? '0 : beat_cnt + BEAT_CNT_W'(1);

        tmo_cnt_nxt = '0;
        if (state == WAIT && !cim_done && !tmo_hit) tmo_cnt_nxt = tmo_cnt + TMO_W'(1);

        err_tmo_nxt = err_tmo | ((state == WAIT) & ~cim_done & tmo_hit);

        cim_start_nxt = (state_nxt == ISSUE);
        vec_valid_nxt = (state_nxt != FILL);
        busy_nxt      = (state_nxt != FILL);

        if (abort) begin
            beat_cnt_nxt = '0;
            tmo_cnt_nxt  = '0;
            err_tmo_nxt  = 1'b0;
        end
    end

    fp8_vec_buffer u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_beat (beat_cnt),
        .wr_data (in_data),
        .vec     (vec)
    );

endmodule

// File: tb/tb_fp8_cim_sequencer.sv
// Self-checking bench for fp8_cim_sequencer: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the sequencer.
module tb_fp8_cim_sequencer;
    import fp8_cim_pkg::*;

    localparam int VW = FP8_W * N_ELEM;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BEAT_W-1:0] in_data = '0;
    logic              abort = 1'b0;
    fp8_t [N_ELEM-1:0] vec;
    logic              vec_valid;
    logic              cim_start;
    logic              cim_done = 1'b0;
    logic              busy;
    logic              err_tmo;

    fp8_cim_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .vec       (vec),
        .vec_valid (vec_valid),
        .cim_start (cim_start),
        .cim_done  (cim_done),
        .busy      (busy),
        .err_tmo   (err_tmo)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_start = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model tracks the operation as: beats collected so far, whether a start
    // pulse is being issued, and how long the current CIM operation has been pending.
    logic [7:0]    m_vec [N_ELEM];
    int            m_beats   = 0;
    bit            m_issue   = 1'b0;
    bit            m_pending = 1'b0;
    int            m_age     = 0;
    bit            m_err     = 1'b0;
    logic [VW-1:0] exp_q [$];

    initial for (int i = 0; i < N_ELEM; i++) m_vec[i] = 8'h00;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ELEM; i++) m_vec[i] = 8'h00;
            m_beats = 0; m_issue = 0; m_pending = 0; m_age = 0; m_err = 0;
        end else if (abort) begin
            m_beats = 0; m_issue = 0; m_pending = 0; m_age = 0; m_err = 0;
        end else if (m_issue) begin
            m_issue = 0; m_pending = 1; m_age = 0;
        end else if (m_pending) begin
            if (cim_done) m_pending = 0;
            else if (m_age == TMO_CYC) begin m_err = 1; m_pending = 0; end
            else m_age++;
        end else if (in_valid) begin
            logic [VW-1:0] snap;
            for (int k = 0; k < EPB; k++) m_vec[m_beats*EPB + k] = in_data[8*k +: 8];
            m_beats++;
            if (m_beats == BEATS) begin
                m_beats = 0;
                m_issue = 1;
                for (int i = 0; i < N_ELEM; i++) snap[8*i +: 8] = m_vec[i];
                exp_q.push_back(snap);
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [VW-1:0] dv;
            int bad;
            dv = vec;
            bad = -1;
            check("in_ready",  in_ready,  !(m_issue || m_pending) && !abort);
            check("cim_start", cim_start, m_issue);
            check("vec_valid", vec_valid, m_issue || m_pending);
            check("busy",      busy,      m_issue || m_pending);
            check("err_tmo",   err_tmo,   m_err);
            for (int i = N_ELEM - 1; i >= 0; i--) if (dv[8*i +: 8] !== m_vec[i]) bad = i;
            n_chk++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL vec[%0d]: got %0h, expected %0h (t=%0t)", bad, dv[8*bad +: 8], m_vec[bad], $time);
            end
            if (cim_start === 1'b1) begin
                n_start++;
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL start_unexpected: got cim_start=1, expected no start (t=%0t)", $time);
                end else if (dv !== exp_q.pop_front()) begin
                    n_fail++;
                    $display("FAIL start_vec: vector at start differs from collected beats (t=%0t)", $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic snap_start, snap_busy, snap_err, snap_vv, acc;

    task automatic drive_cycle(input logic v, input logic [BEAT_W-1:0] d, input logic dn, input logic ab);
        @(negedge clk);
        snap_start = cim_start; snap_busy = busy; snap_err = err_tmo; snap_vv = vec_valid;
        #1;
        in_valid = v; in_data = d; cim_done = dn; abort = ab;
        #1;
        acc = v & in_ready;
    endtask

    task automatic send_beat(input logic [BEAT_W-1:0] d, input logic dn);
        bit ok = 0;
        repeat ($urandom_range(0, 2)) drive_cycle(1'b0, BEAT_W'($urandom), dn, 1'b0);
        for (int t = 0; t < 40 && !ok; t++) begin
            drive_cycle(1'b1, d, dn, 1'b0);
            ok = acc;
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL beat_accept: got no accept in 40 cycles, expected accept (t=%0t)", $time);
        end
    endtask

    task automatic send_vector_rand(input logic dn);
        for (int b = 0; b < BEATS; b++) send_beat(BEAT_W'($urandom), dn);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [BEAT_W-1:0] bdat [BEATS];
        logic [VW-1:0]     flat;
        int                n_cyc;
        int                s0;
        bit                ok;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        flat = vec;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_vec_zero", (flat == '0), 1);
        #1 rst_n = 1'b1;

        // Incrementing pattern: element i must hold i.
        for (int b = 0; b < BEATS; b++) send_beat(32'h03020100 + 32'(b) * 32'h04040404, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check("start_latency", snap_start, 1);
        flat = vec;
        ok = 1;
        for (int i = 0; i < N_ELEM; i++) if (flat[8*i +: 8] !== 8'(i)) ok = 0;
        check("vec_pattern", ok, 1);
        repeat (4) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check("done_busy_low", snap_busy, 0);
        check("done_in_ready", in_ready, 1);
        check("done_no_err", snap_err, 0);

        // Timeout: no done at all.
        send_vector_rand(1'b0);
        n_cyc = -1;
        for (int i = 0; i < 300 && n_cyc < 0; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0);
            if (snap_err) n_cyc = i;
        end
        check("tmo_cycles", n_cyc, 257);
        check("tmo_busy_low", snap_busy, 0);

        // Normal vector afterwards; error stays sticky.
        send_vector_rand(1'b0);
        repeat (3) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check("tmo_sticky", snap_err, 1);
        check("after_tmo_idle", snap_busy, 0);

        // Abort while beat 4 is offered.
        for (int b = 0; b < 4; b++) send_beat(BEAT_W'($urandom), 1'b0);
        drive_cycle(1'b1, 32'hdeadbeef, 1'b0, 1'b1);
        check("abort_no_accept", acc, 0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check("abort_clr_err", snap_err, 0);
        for (int b = 0; b < BEATS; b++) begin
            bdat[b] = BEAT_W'($urandom);
            send_beat(bdat[b], 1'b0);
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check("abort_refill_start", snap_start, 1);
        flat = vec;
        check("abort_elem0", flat[7:0], bdat[0][7:0]);
        check("abort_elem16", flat[8*16 +: 8], bdat[4][7:0]);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0);

        // cim_done held high throughout: only the first wait cycle honours it.
        s0 = n_start;
        send_vector_rand(1'b1);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        check("done_hi_start", snap_start, 1);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        check("done_hi_wait1", snap_busy, 1);
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check("done_hi_end", snap_busy, 0);
        check("done_hi_one_start", n_start - s0, 1);

        // Reset in the middle of a wait with in_valid toggling.
        send_vector_rand(1'b0);
        repeat (3) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        s0 = n_start;
        @(negedge clk); #1 rst_n = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        flat = vec;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_vv", vec_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_vec", (flat == '0), 1);
        #1 in_valid = 1'b0;
        @(negedge clk); #1 in_valid = 1'b1; rst_n = 1'b1;
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check("mid_rst_no_start", n_start - s0, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++)
            drive_cycle(1'($urandom_range(0, 1)), BEAT_W'($urandom),
                        1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0));
        repeat (4) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        check("exp_q_drained", exp_q.size(), 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1, "bench time limit");
    end

endmodule
